tea_cipher_engine: RTL and testbench

Iterative, parametrised TEA block cipher engine. It encrypts or decrypts one 64-bit block per transaction under a 128-bit key. Round count and rounds-per-cycle unroll are configurable. Valid/ready handshakes on input and output replace the single-cycle start/done pulse interface of the first-generation TEA top, so the engine can sit directly on a streaming datapath with backpressure.

---
 rtl/tea_cipher_engine.sv | 163 ++++++++++++++++
 tb/tb_tea_cipher_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_cipher_engine.sv
// Iterative TEA block cipher engine with valid/ready handshakes on both sides.
// Computes ROUNDS_PER_CYCLE TEA cycles per clock, ROUNDS TEA cycles per block.
module tea_cipher_engine #(
  parameter int          ROUNDS           = 32,
  parameter int          ROUNDS_PER_CYCLE = 1,
  parameter logic [31:0] DELTA            = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [63:0]  in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_mode,
  output logic         busy
);

  localparam int N     = ROUNDS / ROUNDS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  // Decryption walks the key schedule backwards from the final encrypt sum.
  localparam logic [31:0] DEC_SUM_INIT = 32'(64'(DELTA) * 64'(ROUNDS));

  if (ROUNDS < 1) begin : g_bad_rounds
    $error("tea_cipher_engine: ROUNDS must be >= 1");
  end
  if (ROUNDS_PER_CYCLE < 1 || (ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_unroll
    $error("tea_cipher_engine: ROUNDS_PER_CYCLE must divide ROUNDS exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      v0_q, v0_d;
  logic [31:0]      v1_q, v1_d;
  logic [31:0]      sum_q, sum_d;
  logic [127:0]     key_q, key_d;
  logic             mode_q, mode_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_mode_q, out_mode_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] rv0, rv1, rsum;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  function automatic logic [31:0] tea_mix(
    input logic [31:0] v,
    input logic [31:0] s,
    input logic [31:0] ka,
    input logic [31:0] kb
  );
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  // Chain of ROUNDS_PER_CYCLE TEA cycles starting from the registered state.
  always_comb begin
    rv0  = v0_q;
    rv1  = v1_q;
    rsum = sum_q;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      if (!mode_q) begin
        rsum = rsum + DELTA;
        rv0  = rv0 + tea_mix(rv1, rsum, k0, k1);
        rv1  = rv1 + tea_mix(rv0, rsum, k2, k3);
      end else begin
        rv1  = rv1 - tea_mix(rv0, rsum, k2, k3);
        rv0  = rv0 - tea_mix(rv1, rsum, k0, k1);
        rsum = rsum - DELTA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      sum_q      <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
      out_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      sum_q      <= sum_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Inputs are only captured on accept; result registers only load on the last round.
  always_comb begin
    cnt_d      = cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    sum_d      = sum_q;
    key_d      = key_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_mode_d = out_mode_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          v0_d   = in_data[63:32];
          v1_d   = in_data[31:0];
          key_d  = in_key;
          mode_d = in_mode;
          cnt_d  = '0;
          sum_d  = in_mode ? DEC_SUM_INIT : 32'd0;
        end
      end
      RUN: begin
        v0_d  = rv0;
        v1_d  = rv1;
        sum_d = rsum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          out_data_d = {rv0, rv1};
          out_mode_d = mode_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = out_data_q;
    out_mode  = out_mode_q;
  end

endmodule

// File: tb/tb_tea_cipher_engine.sv
// Scoreboard bench for tea_cipher_engine: three builds (32x1, 32x4, 1x1) driven
// with directed vectors; a negedge monitor pops expected results on each handshake.
module tb_tea_cipher_engine;

  localparam logic [63:0]  C0  = 64'h41EA3A0A_94BAA940;
  localparam logic [63:0]  C1R = 64'h9E3779B9_DBE8D32F;
  localparam logic [63:0]  PT  = 64'h0123456789ABCDEF;
  localparam logic [127:0] KY  = 128'h00112233445566778899AABBCCDDEEFF;

  typedef struct {
    int          unit;
    logic        mode;
    logic        chk;
    logic [63:0] data;
    int          lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         in_mode   [3];
  logic [63:0]  in_data   [3];
  logic [127:0] in_key    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [63:0]  out_data  [3];
  logic         out_mode  [3];
  logic         busy      [3];

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle_cnt = 0;
  int          acc_m   [3];
  int          lat_m   [3];
  logic        prev_valid [3];
  logic [63:0] last_out [3];

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  tea_cipher_engine #(.ROUNDS(32), .ROUNDS_PER_CYCLE(1)) u_dut32x1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
    .in_data(in_data[0]), .in_key(in_key[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_mode(out_mode[0]), .busy(busy[0])
  );

  tea_cipher_engine #(.ROUNDS(32), .ROUNDS_PER_CYCLE(4)) u_dut32x4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
    .in_data(in_data[1]), .in_key(in_key[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_mode(out_mode[1]), .busy(busy[1])
  );

  tea_cipher_engine #(.ROUNDS(1), .ROUNDS_PER_CYCLE(1)) u_dut1x1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode[2]),
    .in_data(in_data[2]), .in_key(in_key[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_mode(out_mode[2]), .busy(busy[2])
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives a request on unit u; pushes the expected result on the accepting edge.
  task automatic applyStimulus(input int u, input logic mode, input logic [63:0] data,
                               input logic [127:0] key, input logic chk,
                               input logic [63:0] exp_data, input int lat,
                               input logic keep, output int acc);
    exp_t e;
    bit   got = 1'b0;
    acc = -1;
    in_valid[u] = 1'b1;
    in_mode[u]  = mode;
    in_data[u]  = data;
    in_key[u]   = key;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (in_ready[u] === 1'b1) begin
        e.unit = u;
        e.mode = mode;
        e.chk  = chk;
        e.data = exp_data;
        e.lat  = lat;
        exp_q.push_back(e);
        acc = cycle_cnt + 1;
        got = 1'b1;
      end
    end
    if (!got) checkOutput($sformatf("accept_timeout_u%0d", u), 64'(got), 64'd1);
    @(posedge clk); #1;
    if (!keep) in_valid[u] = 1'b0;
  endtask

  task automatic waitDrain();
    int i = 0;
    while (exp_q.size() != 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: tracks accept/rise times and scores each output handshake.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (in_valid[u] === 1'b1 && in_ready[u] === 1'b1) acc_m[u] = cycle_cnt + 1;
      if (out_valid[u] === 1'b1 && prev_valid[u] !== 1'b1) lat_m[u] = cycle_cnt - acc_m[u];
      prev_valid[u] = out_valid[u];
      if (out_valid[u] === 1'b1 && out_ready[u] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("unexpected_result_u%0d", u), 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput($sformatf("result_unit_u%0d", u), 64'(u), 64'(mon_e.unit));
          if (mon_e.chk) checkOutput($sformatf("result_data_u%0d", u), out_data[u], mon_e.data);
          checkOutput($sformatf("result_mode_u%0d", u), 64'(out_mode[u]), 64'(mon_e.mode));
          checkOutput($sformatf("result_latency_u%0d", u), 64'(lat_m[u]), 64'(mon_e.lat));
          last_out[u] = out_data[u];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit exceeded");
    $fatal(1);
  end

  initial begin
    int a1, a2, a3, acc, n;
    logic [63:0] ct;
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      in_valid[u]  = 1'b0;
      in_mode[u]   = 1'b0;
      in_data[u]   = '0;
      in_key[u]    = '0;
      out_ready[u] = 1'b1;
      last_out[u]  = '0;
      acc_m[u]     = 0;
      lat_m[u]     = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready[0]), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("reset_busy", 64'(busy[0]), 64'd0);
    checkOutput("reset_out_data", out_data[0], 64'd0);
    checkOutput("reset_out_mode", 64'(out_mode[0]), 64'd0);
    checkOutput("reset_busy_u1", 64'(busy[1]), 64'd0);
    checkOutput("reset_busy_u2", 64'(busy[2]), 64'd0);
    @(posedge clk); #1;

    $display("[TB] encrypt/decrypt zero vector, round trip with nonzero key");
    applyStimulus(0, 1'b0, 64'd0, 128'd0, 1'b1, C0, 32, 1'b0, acc); waitDrain();
    applyStimulus(0, 1'b1, C0, 128'd0, 1'b1, 64'd0, 32, 1'b0, acc); waitDrain();
    applyStimulus(0, 1'b0, PT, KY, 1'b0, 64'd0, 32, 1'b0, acc); waitDrain();
    ct = last_out[0];
    applyStimulus(0, 1'b1, ct, KY, 1'b1, PT, 32, 1'b0, acc); waitDrain();

    $display("[TB] backpressure");
    out_ready[0] = 1'b0;
    applyStimulus(0, 1'b0, 64'd0, 128'd0, 1'b1, C0, 32, 1'b0, acc);
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_seen", 64'(out_valid[0]), 64'd1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        in_valid[0] = 1'b1;
        in_mode[0]  = 1'b1;
        in_data[0]  = 64'hDEADBEEF_CAFEF00D;
      end
      @(negedge clk);
      checkOutput("bp_data_stable", out_data[0], C0);
      checkOutput("bp_in_ready", 64'(in_ready[0]), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid[0]), 64'd1);
      checkOutput("bp_out_mode", 64'(out_mode[0]), 64'd0);
    end
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_drain_out_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("bp_drain_in_ready", 64'(in_ready[0]), 64'd1);
    checkOutput("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    $display("[TB] unroll by four");
    applyStimulus(1, 1'b0, 64'd0, 128'd0, 1'b1, C0, 8, 1'b0, acc); waitDrain();
    applyStimulus(1, 1'b1, C0, 128'd0, 1'b1, 64'd0, 8, 1'b0, acc); waitDrain();

    $display("[TB] reset mid-run and reset with in_valid");
    applyStimulus(0, 1'b0, 64'd0, 128'd0, 1'b1, C0, 32, 1'b0, acc);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_run_in_ready", 64'(in_ready[0]), 64'd1);
    checkOutput("rst_run_out_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("rst_run_busy", 64'(busy[0]), 64'd0);
    checkOutput("rst_run_out_data", out_data[0], 64'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    reset       = 1'b1;
    in_valid[0] = 1'b1;
    in_mode[0]  = 1'b0;
    in_data[0]  = 64'd0;
    in_key[0]   = 128'd0;
    @(posedge clk); #1;
    reset       = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid_busy", 64'(busy[0]), 64'd0);
    checkOutput("rst_valid_in_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 64'd0, 128'd0, 1'b1, C0, 32, 1'b0, acc); waitDrain();

    $display("[TB] back-to-back blocks");
    applyStimulus(0, 1'b0, 64'd0, 128'd0, 1'b1, C0, 32, 1'b1, a1);
    applyStimulus(0, 1'b1, C0, 128'd0, 1'b1, 64'd0, 32, 1'b1, a2);
    applyStimulus(0, 1'b0, 64'd0, 128'd0, 1'b1, C0, 32, 1'b0, a3);
    checkOutput("b2b_gap_1_2", 64'(a2 - a1), 64'd34);
    checkOutput("b2b_gap_2_3", 64'(a3 - a2), 64'd34);
    waitDrain();

    $display("[TB] single round build");
    applyStimulus(2, 1'b0, 64'd0, 128'd0, 1'b1, C1R, 1, 1'b0, acc); waitDrain();
    applyStimulus(2, 1'b1, C1R, 128'd0, 1'b1, 64'd0, 1, 1'b0, acc); waitDrain();

    checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
